// File: rtl/cic_pkg.sv
// ---------------------------------------------------------------------------
// cic_pkg
// Shared helpers for the parametrised CIC decimator:
//   clog2         - ceiling log2 used to size counters and accumulators
//   acc_width     - accumulator width that guarantees no information loss
//                   (wrap-around inside the chain is then harmless)
//   settle_width  - width of the settle counter (never below 3 bits)
//   clamp_ratio   - maps a requested decimation ratio onto 2..R_MAX
//   sat_max/min   - signed full-scale limits of a W-bit output
// ---------------------------------------------------------------------------
package cic_pkg;

    localparam int SETTLE_MIN_W = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic int acc_width(input int in_w, input int n, input int r_max, input int m);
        return in_w + n * clog2(r_max * m);
    endfunction

    function automatic int settle_width(input int n, input int m);
        int w;
        w = clog2(n * m + 1);
        return (w < SETTLE_MIN_W) ? SETTLE_MIN_W : w;
    endfunction

    function automatic int clamp_ratio(input int req, input int r_max);
        int r;
        if (req < 2) begin
            r = 2;
        end else if (req > r_max) begin
            r = r_max;
        end else begin
            r = req;
        end
        return r;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// ---------------------------------------------------------------------------
// cic_comb_stage
// One comb section y[n] = x[n] - x[n-M] of the decimated CIC path. The
// M-deep delay line and the output only advance when in_valid is high, so
// the stage runs at the decimated rate inside the system clock domain.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   in_valid   - input sample strobe (decimated rate)
//   x          - signed input sample
//   out_valid  - registered strobe, one cycle after in_valid
//   y          - registered signed difference, modulo 2^ACC_W
// ---------------------------------------------------------------------------
module cic_comb_stage #(
    parameter int ACC_W = 32,
    parameter int M     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] x,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] y
);

    logic signed [ACC_W-1:0] dly_q [M];
    logic signed [ACC_W-1:0] dly_d [M];
    logic signed [ACC_W-1:0] y_q;
    logic signed [ACC_W-1:0] y_d;
    logic                    valid_q;

    // Difference against the oldest delay tap; delay line shifts on in_valid only
    always_comb begin
        dly_d = dly_q;
        y_d   = y_q;
        if (in_valid) begin
            y_d      = x - dly_q[M-1];
            dly_d[0] = x;
            for (int i = 1; i < M; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end else begin
            dly_d = dly_q;
            y_d   = y_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                dly_q[i] <= '0;
            end
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            dly_q   <= dly_d;
            y_q     <= y_d;
            valid_q <= in_valid;
        end
    end

    assign y         = y_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/cic_decim_param.sv
// ---------------------------------------------------------------------------
// cic_decim_param
// Single-clock CIC decimator: N integrators at the input rate (clock-enabled
// by din_valid), a run-time programmable decimation counter, a decimation
// register, N comb stages at the decimated rate, then gain shift and
// saturation into a registered output.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   din_valid     - input sample strobe, any duty cycle
//   din           - signed IN_W input sample
//   dec_ratio     - requested ratio R, clamped to 2..R_MAX, taken at frame ends
//   gain_shift    - arithmetic right shift applied before saturation
//   dout          - signed OUT_W decimated output, held between strobes
//   dout_valid    - one-cycle strobe, N+2 cycles after the frame's last sample
//   sat           - dout was clamped; qualified by dout_valid
//   ratio_active  - ratio currently used by the sample counter
// ---------------------------------------------------------------------------
module cic_decim_param
    import cic_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int N     = 5,
    parameter int M     = 1,
    parameter int R_MAX = 64,
    parameter int OUT_W = 32,
    parameter int ACC_W = acc_width(IN_W, N, R_MAX, M),
    parameter int RW    = clog2(R_MAX) + 1,
    parameter int SW    = clog2(ACC_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [IN_W-1:0]  din,
    input  logic [RW-1:0]           dec_ratio,
    input  logic [SW-1:0]           gain_shift,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    sat,
    output logic [RW-1:0]           ratio_active
);

    localparam int SET_W = settle_width(N, M);
    // Output-stage comparison width wide enough for both ranges plus sign
    localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'(sat_max(OUT_W));
    localparam logic signed [EXT_W-1:0] OUT_MIN = EXT_W'(sat_min(OUT_W));

    // Integrators
    logic signed [ACC_W-1:0] integ_q [N];
    logic signed [ACC_W-1:0] integ_d [N];

    // Frame control
    logic [RW-1:0]    ratio_req_s;
    logic [RW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    ratio_q, ratio_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             strobe_q, strobe_d;
    logic             strobe_keep_q, strobe_keep_d;

    // Decimation register and keep-flag pipeline
    logic signed [ACC_W-1:0] dec_q, dec_d;
    logic                    dec_valid_q, dec_valid_d;
    logic                    dec_keep_q, dec_keep_d;
    logic [N-1:0]            keep_pipe_q, keep_pipe_d;

    // Comb chain taps: index 0 is the decimation register, index N the tail
    logic signed [ACC_W-1:0] comb_x_s [N+1];
    logic [N:0]              comb_v_s;

    // Output stage
    logic signed [ACC_W-1:0] shifted_s;
    logic signed [EXT_W-1:0] t_ext_s;
    logic signed [OUT_W-1:0] dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    sat_q, sat_d;

    assign ratio_req_s = RW'(clamp_ratio(int'(dec_ratio), R_MAX));

    // Integrator cascade, advancing only on accepted input samples
    always_comb begin
        integ_d = integ_q;
        if (din_valid) begin
            integ_d[0] = integ_q[0] + ACC_W'(din);
            for (int k = 1; k < N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end else begin
            integ_d = integ_q;
        end
    end

    // Sample counter, frame-boundary ratio update and settle bookkeeping.
    // A frame whose strobe coincides with a ratio change still ends with the
    // old ratio; its own output is the first of the N*M suppressed ones.
    always_comb begin
        cnt_d         = cnt_q;
        ratio_d       = ratio_q;
        settle_d      = settle_q;
        strobe_d      = 1'b0;
        strobe_keep_d = 1'b0;
        if (din_valid) begin
            if (cnt_q == (ratio_q - RW'(1'b1))) begin
                cnt_d    = '0;
                strobe_d = 1'b1;
                ratio_d  = ratio_req_s;
                if (ratio_req_s != ratio_q) begin
                    strobe_keep_d = 1'b0;
                    settle_d      = SET_W'(N * M - 1);
                end else if (settle_q != '0) begin
                    strobe_keep_d = 1'b0;
                    settle_d      = settle_q - SET_W'(1'b1);
                end else begin
                    strobe_keep_d = 1'b1;
                    settle_d      = settle_q;
                end
            end else begin
                cnt_d = cnt_q + RW'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Decimation register and keep flag aligned with the comb chain latency
    always_comb begin
        dec_valid_d = strobe_q;
        dec_keep_d  = strobe_keep_q;
        keep_pipe_d = '0;
        if (strobe_q) begin
            dec_d = integ_q[N-1];
        end else begin
            dec_d = dec_q;
        end
        keep_pipe_d[0] = dec_valid_q & dec_keep_q;
        for (int i = 1; i < N; i++) begin
            keep_pipe_d[i] = keep_pipe_q[i-1];
        end
    end

    assign comb_x_s[0] = dec_q;
    assign comb_v_s[0] = dec_valid_q;

    for (genvar j = 0; j < N; j++) begin : g_comb
        cic_comb_stage #(
            .ACC_W (ACC_W),
            .M     (M)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (comb_v_s[j]),
            .x         (comb_x_s[j]),
            .out_valid (comb_v_s[j+1]),
            .y         (comb_x_s[j+1])
        );
    end

    // Gain shift and saturation; suppressed (settling) outputs leave dout untouched
    always_comb begin
        shifted_s    = comb_x_s[N] >>> gain_shift;
        t_ext_s      = EXT_W'(shifted_s);
        dout_d       = dout_q;
        sat_d        = sat_q;
        dout_valid_d = 1'b0;
        if (comb_v_s[N] && keep_pipe_q[N-1]) begin
            dout_valid_d = 1'b1;
            if (t_ext_s > OUT_MAX) begin
                dout_d = OUT_W'(OUT_MAX);
                sat_d  = 1'b1;
            end else if (t_ext_s < OUT_MIN) begin
                dout_d = OUT_W'(OUT_MIN);
                sat_d  = 1'b1;
            end else begin
                dout_d = OUT_W'(t_ext_s);
                sat_d  = 1'b0;
            end
        end else begin
            dout_d       = dout_q;
            sat_d        = sat_q;
            dout_valid_d = 1'b0;
        end
    end

    // All top-level state; reset loads the clamped requested ratio
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q         <= '0;
            ratio_q       <= ratio_req_s;
            settle_q      <= SET_W'(N * M);
            strobe_q      <= 1'b0;
            strobe_keep_q <= 1'b0;
            dec_q         <= '0;
            dec_valid_q   <= 1'b0;
            dec_keep_q    <= 1'b0;
            keep_pipe_q   <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            integ_q       <= integ_d;
            cnt_q         <= cnt_d;
            ratio_q       <= ratio_d;
            settle_q      <= settle_d;
            strobe_q      <= strobe_d;
            strobe_keep_q <= strobe_keep_d;
            dec_q         <= dec_d;
            dec_valid_q   <= dec_valid_d;
            dec_keep_q    <= dec_keep_d;
            keep_pipe_q   <= keep_pipe_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            sat_q         <= sat_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign sat          = sat_q;
    assign ratio_active = ratio_q;

endmodule

// File: tb/tb_cic_decim_param.sv
// Directed bench for cic_decim_param: two instances (OUT_W=32 and OUT_W=16)
// share one stimulus. Expected outputs are pushed when a frame's last sample
// is driven and popped when dout_valid rises.
module tb_cic_decim_param;

    localparam int N     = 5;
    localparam int M     = 1;
    localparam int R_MAX = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              din_valid;
    logic signed [1:0] din;
    logic [6:0]        dec_ratio;
    logic [4:0]        gain_shift;

    logic signed [31:0] dout32;
    logic               valid32, sat32;
    logic [6:0]         ra32;
    logic signed [15:0] dout16;
    logic               valid16, sat16;
    logic [6:0]         ra16;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        int                 cyc;
        logic signed [63:0] v32;
        logic               s32;
        logic signed [63:0] v16;
        logic               s16;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference of the frame counter as seen from the input side
    int m_cnt    = 0;
    int m_ratio  = 2;
    int m_settle = N * M;

    cic_decim_param #(.OUT_W(32)) u_dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .dec_ratio(dec_ratio), .gain_shift(gain_shift),
        .dout(dout32), .dout_valid(valid32), .sat(sat32), .ratio_active(ra32)
    );

    cic_decim_param #(.OUT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .dec_ratio(dec_ratio), .gain_shift(gain_shift),
        .dout(dout16), .dout_valid(valid16), .sat(sat16), .ratio_active(ra16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clampr(input int r);
        if (r < 2) return 2;
        if (r > R_MAX) return R_MAX;
        return r;
    endfunction

    // Steady-state DC output: din * R^N, shifted, saturated to w bits
    function automatic void expect_out(input int d, input int r, input int gs, input int w,
                                       output logic signed [63:0] v, output logic s);
        longint p, mx, mn;
        p = d;
        for (int i = 0; i < N; i++) p = p * r;
        p  = p >>> gs;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (p > mx) begin
            v = mx; s = 1'b1;
        end else if (p < mn) begin
            v = mn; s = 1'b1;
        end else begin
            v = p; s = 1'b0;
        end
    endfunction

    // One clock: drive din_valid, let the edge happen, update the frame model
    task automatic step(input logic v);
        exp_t ent;
        int   nr;
        int   d;
        logic chg, keep;
        din_valid = v;
        @(posedge clk);
        #1;
        d = din;
        if (rst) begin
            m_cnt    = 0;
            m_settle = N * M;
            m_ratio  = clampr(int'(dec_ratio));
            sb.delete();
        end else if (v) begin
            if (m_cnt == m_ratio - 1) begin
                m_cnt = 0;
                nr    = clampr(int'(dec_ratio));
                chg   = (nr != m_ratio);
                keep  = !chg && (m_settle == 0);
                if (chg) m_settle = N * M - 1;
                else if (m_settle > 0) m_settle--;
                if (keep) begin
                    ent.cyc = cyc + N + 2;
                    expect_out(d, m_ratio, int'(gain_shift), 32, ent.v32, ent.s32);
                    expect_out(d, m_ratio, int'(gain_shift), 16, ent.v16, ent.s16);
                    sb.push_back(ent);
                end
                m_ratio = nr;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < N + 4; i++) step(1'b0);
        check("sb_drained", sb.size(), 0);
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (valid32 === 1'b1) begin
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                check("dout32", dout32, mon_e.v32);
                check("sat32", sat32, mon_e.s32);
                check("valid16", valid16, 1);
                check("dout16", dout16, mon_e.v16);
                check("sat16", sat16, mon_e.s16);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            check("valid32_missing", valid32, 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b1;
        din        = 2'sd1;
        dec_ratio  = 7'd8;
        gain_shift = 5'd0;

        // 1: reset values while din_valid is high
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check("rst_dout", dout32, 0);
            check("rst_valid", valid32, 0);
            check("rst_sat", sat32, 0);
            check("rst_ratio", ra32, 8);
        end
        rst = 1'b0;

        // 2: DC gain +1, R=8 -> 32768 (16-bit instance clamps to 32767)
        run(64);
        drain();
        gain_shift = 5'd1;
        run(24);
        drain();

        // 2b: din=-1 with gapped input strobes -> -32768 (exact 16-bit minimum)
        gain_shift = 5'd0;
        din        = -2'sd1;
        do_reset();
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)));
        drain();

        // 3: full scale, R=64, din=-2 -> -2^31; 16-bit instance saturates
        din       = -2'sd2;
        dec_ratio = 7'd64;
        do_reset();
        run(64 * 8);
        drain();

        // 4: R=2 continuous input: outputs every 2 cycles, fixed latency
        din       = 2'sd1;
        dec_ratio = 7'd2;
        do_reset();
        check("ratio_r2", ra32, 2);
        run(30);
        drain();

        // 5: ratio change 8 -> 16 mid-frame
        dec_ratio = 7'd8;
        do_reset();
        run(56);
        run(4);
        dec_ratio = 7'd16;
        run(3);
        check("ratio_hold_mid_frame", ra32, 8);
        run(1);
        check("ratio_at_boundary", ra32, 16);
        run(16 * 7);
        drain();

        // clamp rule at reset
        dec_ratio = 7'd0;
        rst = 1'b1;
        step(1'b1);
        check("clamp_low", ra32, 2);
        dec_ratio = 7'd100;
        step(1'b1);
        check("clamp_high", ra16, 64);
        rst = 1'b0;

        // 6: reset at sample 5 of 8 discards the frame and restarts settling
        dec_ratio = 7'd8;
        do_reset();
        run(56);
        run(4);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        check("midrst_valid", valid32, 0);
        run(56);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cic_decim_param.md
Name: cic_decim_param

Overview:
- Parametrised, single-clock CIC decimator that replaces the fixed integrator/decimator/comb chain and its divided clock.
- Input samples arrive on a clock-enable strobe (din_valid) in the system clock domain.
- Order N, differential delay M and maximum ratio are generics; the decimation ratio is run-time programmable, with gain shift and output saturation.
- Sits in front of the ISOP compensator and the half-band stage; the dout_valid strobe plays the role of the former ND.

Parameters:
- IN_W, 2, signed input width
- N, 5, number of integrator and comb stages
- M, 1, differential delay (1 or 2)
- R_MAX, 64, maximum decimation ratio
- OUT_W, 32, signed output width
- ACC_W, IN_W+N*clog2(R_MAX*M), accumulator width (32 at defaults)
- RW, clog2(R_MAX)+1, width of dec_ratio
- SW, clog2(ACC_W), width of gain_shift

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset; synchronous, active-high
- din_valid, in, 1, input sample strobe; any duty cycle
- din, in, IN_W, signed input sample
- dec_ratio, in, RW, requested decimation ratio R
- gain_shift, in, SW, arithmetic right shift applied before saturation
- dout, out, OUT_W, signed decimated output
- dout_valid, out, 1, one-cycle output strobe
- sat, out, 1, this output was clamped; qualified by dout_valid
- ratio_active, out, RW, ratio currently in use

Behaviour:
- Reset (rst=1 at a clk edge) clears all integrators, comb delay lines, pipeline valids, sample counter and settle counter.
- Reset values: dout=0, dout_valid=0, sat=0, ratio_active=clamp(dec_ratio).
- Reset asserted mid-frame discards the partial frame. The first output after release requires a full R samples plus settling.
- Clamp rule: dec_ratio<2 is treated as 2; dec_ratio>R_MAX is treated as R_MAX.
- Integrators: N cascaded ACC_W registers, all updated only when din_valid=1.
  - Stage 1 adds sign-extended din; stage k adds the stage k-1 register.
  - Wrap-around (modulo 2^ACC_W) is intended. No saturation inside the chain.
- Sample counter: counts accepted samples 0..R-1.
  - On the edge accepting sample R-1, the counter returns to 0 and a decimation strobe is raised.
  - At that same edge, ratio_active <= clamp(dec_ratio). Ratio changes therefore only take effect at frame boundaries.
- Pipeline: let the strobe sample be accepted at edge k.
  - Edge k+1: decimation register captures integrator N.
  - Edges k+2..k+N+1: comb stages j=1..N compute y=x-x[n-M] on their own valid. Each stage has an M-deep delay line that advances only on its valid.
  - Edge k+N+2: output register. dout_valid is high for exactly the cycle after edge k+N+2, so latency is N+2 clk cycles.
- The pipeline is fully pipelined: back-to-back strobes every 2 cycles (R=2, din_valid constantly 1) are sustained with no stall.
- Output stage:
  - t = comb_out >>> gain_shift (arithmetic).
  - If t exceeds the OUT_W signed range, dout is clamped to max/min and sat=1; otherwise sat=0.
  - dout and sat hold their values between strobes.
- Settle: after reset or any ratio_active change, the first N*M decimated outputs are computed but dout_valid is suppressed. A 3-bit-plus settle counter is reloaded on each change.
- Simultaneous events:
  - rst beats din_valid.
  - A ratio change coincident with the strobe applies to the next frame; the current frame completes with the old R.

Decomposition:
- Shared package cic_pkg:
  - clog2 function
  - ACC_W derivation function
  - clamp_ratio function
  - saturation min/max constants helper
- One natural sub-module, cic_comb_stage (parameters ACC_W, M; ports clk, rst, in_valid, x, out_valid, y), instantiated N times through a generate loop.
- Integrators, sample counter and output stage stay in the top module.

Test Plan:
1. Reset values: hold rst for 3 cycles with din_valid=1 and din=1 -> dout=0, dout_valid=0, sat=0 throughout; ratio_active=8 when dec_ratio=8.
2. DC gain: N=5, M=1, dec_ratio=8, gain_shift=0, din=+1 on every cycle -> after the settle outputs, every dout=32768 with sat=0. din=-1 -> dout=-32768.
3. Full scale: dec_ratio=64, din=-2 continuous -> settled dout=-2^31, sat=0. Then gain_shift=0 with OUT_W=16 -> dout=-32768 and sat=1.
4. Latency and throughput: dec_ratio=2, din_valid=1 continuously -> dout_valid pulses every 2 cycles; the first valid pulse is exactly N+2 cycles after the strobe edge of the first post-settle frame.
5. Ratio change: switch dec_ratio from 8 to 16 mid-frame -> the current frame ends at 8 samples and ratio_active updates at that edge; 5 outputs are suppressed; the next valid dout=16^5=1048576. Also dec_ratio=0 -> ratio_active=2.
6. Reset mid-operation: assert rst for 1 cycle at sample 5 of 8 -> no dout_valid until the full settle sequence repeats; the first settled output equals the value from scenario 2.
